// File: rtl/spi_master.sv
// SPI mode-0 controller (CPOL=0, CPHA=0, MSB first) with a valid/ready byte interface.
// It drives sclk, mosi and ce0, samples miso on each sclk rise, and pulses rx_valid when a transfer ends.
module spi_master #(
    parameter int DATA_W   = 8,
    parameter int CLK_DIV  = 6,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              ce0
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int HW     = $clog2(CLK_DIV + 1);
    localparam int BW     = $clog2(DATA_W + 1);
    localparam int CW     = $clog2(CS_MAX + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] B_LAST  = BW'(DATA_W - 1);
    localparam logic [CW-1:0] CS_SLST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] CS_HLST = CW'(CS_HOLD - 1);

    logic [1:0]        state;
    logic [HW-1:0]     hcnt;
    logic [BW-1:0]     bcnt;
    logic [CW-1:0]     cs_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;

    // Holding off while rx_valid is high keeps ce0 high for at least two cycles between transfers.
    assign tx_ready = (state == IDLE) && !rx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            cs_cnt   <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ce0      <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sr  <= tx_data;
                        mosi   <= tx_data[DATA_W-1];
                        ce0    <= 1'b0;
                        busy   <= 1'b1;
                        cs_cnt <= '0;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cs_cnt == CS_SLST) begin
                        cs_cnt <= '0;
                        hcnt   <= '0;
                        bcnt   <= '0;
                        state  <= XFER;
                    end else begin
                        cs_cnt <= cs_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (hcnt == H_LAST) begin
                        hcnt <= '0;
                        sclk <= !sclk;
                        if (!sclk) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], miso};
                        end else if (bcnt == B_LAST) begin
                            // mosi keeps the last bit through HOLD
                            state <= HOLD;
                        end else begin
                            tx_sr <= tx_sr << 1;
                            mosi  <= tx_sr[DATA_W-2];
                            bcnt  <= bcnt + 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cs_cnt == CS_HLST) begin
                        cs_cnt   <= '0;
                        ce0      <= 1'b1;
                        busy     <= 1'b0;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        cs_cnt <= cs_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: a scoreboard driven from the stimulus side, an independent monitor, and a mode-0 peripheral model.
// A second instance with the smallest timing parameters is checked directly.
module tb_spi_master;
    localparam int DW  = 8;
    localparam int CD  = 6;
    localparam int CSS = 2;
    localparam int CSH = 2;
    localparam int LAT  = 1 + CSS + 2*DW*CD + CSH;   // handshake cycle to rx_valid cycle
    localparam int LAT1 = 1 + 1 + 2*DW*1 + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DUT 0: default parameters, miso from loopback or from the peripheral model
    logic [DW-1:0] tx_data = '0, rx_data;
    logic tx_valid = 1'b0, tx_ready, rx_valid, busy, sclk, mosi, miso, ce0;
    logic loop = 1'b1;
    logic [DW-1:0] s_sr = '0, cap = '0;
    assign miso = loop ? mosi : s_sr[DW-1];

    spi_master #(.DATA_W(DW), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .mosi(mosi),
        .miso(miso), .ce0(ce0));

    // DUT 1: minimum timing, loopback
    logic [DW-1:0] tx_data1 = '0, rx_data1;
    logic tx_valid1 = 1'b0, tx_ready1, rx_valid1, busy1, sclk1, mosi1, ce01;

    spi_master #(.DATA_W(DW), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1), .mosi(mosi1),
        .miso(mosi1), .ce0(ce01));

    typedef struct {
        logic [DW-1:0] rx;
        logic [DW-1:0] tx;
        int            cyc;
    } exp_t;
    exp_t          sb[$];
    logic [DW-1:0] sq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Mode-0 peripheral: presents its MSB when ce0 falls, shifts on sclk fall, captures mosi on sclk rise.
    always @(negedge ce0) if (sq.size() > 0) s_sr = sq.pop_front();
    always @(negedge sclk) if (!ce0) s_sr = {s_sr[DW-2:0], 1'b0};
    always @(posedge sclk) cap = {cap[DW-2:0], mosi};

    // Monitor for DUT 0
    int   rises = 0;
    int   gap = 0;
    bit   seen_xfer = 0;
    logic sclk_q = 1'b0, mosi_q = 1'b0, rxv_q = 1'b0, ce0_q = 1'b1;
    always @(negedge clk) begin
        if (!rst_n) begin
            rises = 0; gap = 0; seen_xfer = 0;
            sclk_q = 1'b0; rxv_q = 1'b0; ce0_q = 1'b1; mosi_q = 1'b0;
        end else begin
            exp_t e;
            if (sclk && !sclk_q) begin
                rises++;
                chk("mosi_stable_at_rise", mosi, mosi_q);
            end
            if (ce0) begin
                chk("sclk_idle_while_ce0_high", sclk, 0);
                gap++;
            end else if (ce0_q) begin
                if (seen_xfer) chk("ce0_gap_ge2", gap >= 2, 1);
                gap = 0;
                seen_xfer = 1;
            end
            if (rx_valid) begin
                chk("rx_valid_single_cycle", rxv_q, 0);
                chk("ce0_high_with_rx_valid", ce0, 1);
                chk("sclk_rises_per_xfer", rises, DW);
                rises = 0;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rx_valid: got rx_data %0h expected no transfer", rx_data);
                end else begin
                    e = sb.pop_front();
                    chk("rx_data", rx_data, e.rx);
                    chk("rx_valid_cycle", cyc, e.cyc);
                    chk("periph_captured_byte", cap, e.tx);
                end
            end
            sclk_q = sclk; mosi_q = mosi; rxv_q = rx_valid; ce0_q = ce0;
        end
    end

    // Called at a negedge; returns at the negedge after the handshake.
    task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] s, input bit lp, input bit hold);
        exp_t e;
        int   n = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("tx_ready_timeout", n < 2000, 1);
        loop = lp;
        e.tx  = d;
        e.rx  = lp ? d : s;
        e.cyc = cyc + LAT;
        sb.push_back(e);
        sq.push_back(s);
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic xfer1(input logic [DW-1:0] d);
        int k, n, r, last;
        tx_data1  = d;
        tx_valid1 = 1'b1;
        chk("u1_tx_ready", tx_ready1, 1);
        k = cyc;
        @(negedge clk);
        tx_valid1 = 1'b0;
        n = 0; r = 0; last = 0;
        while (!rx_valid1 && n < 200) begin
            if (sclk1 && ce01 === 1'b0) begin
                if (r > 0) chk("u1_sclk_period", cyc - last, 2);
                last = cyc;
                r++;
            end
            @(negedge clk);
            n++;
        end
        chk("u1_rx_valid_cycle", cyc, k + LAT1);
        chk("u1_rx_data", rx_data1, d);
        chk("u1_sclk_rises", r, DW);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ce0", ce0, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_ready", tx_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        send(8'hA5, 8'h00, 1, 0);
        chk("busy_after_accept", busy, 1);
        chk("ce0_low_after_accept", ce0, 0);
        drain();
        send(8'h81, 8'h3C, 0, 0);
        drain();
        send(8'h01, 8'h11, 1, 1);
        send(8'h80, 8'h22, 1, 1);
        send(8'hFF, 8'h33, 1, 0);
        drain();

        // A request while busy must be ignored.
        send(8'h9A, 8'h00, 1, 0);
        repeat (40) @(negedge clk);
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        drain();
        repeat (150) @(negedge clk);
        chk("no_extra_transfer", sb.size(), 0);

        // Reset during bit 4
        begin
            int n = 0;
            send(8'h5A, 8'h00, 1, 0);
            while (rises < 5 && n < 500) begin
                @(negedge clk);
                n++;
            end
            chk("wait_bit4_timeout", n < 500, 1);
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_ce0", ce0, 1);
            chk("midrst_sclk", sclk, 0);
            chk("midrst_rx_data", rx_data, 0);
            chk("midrst_rx_valid", rx_valid, 0);
            chk("midrst_tx_ready", tx_ready, 1);
            sb.delete();
            sq.delete();
            @(negedge clk);
            @(negedge clk);
            rst_n = 1'b1;
            repeat (150) @(negedge clk);
            chk("post_rst_tx_ready", tx_ready, 1);
            send(8'hC3, 8'h00, 1, 0);
            drain();
        end

        xfer1(8'h6E);
        repeat (2) xfer1(DW'($urandom));

        repeat (20) begin
            send(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
